imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 120 ++++++++++++
 tb/tb_imem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port synchronous RAM between
// the instruction fetch port and a loader port. Fetch normally has priority;
// a starvation counter guarantees the loader a slot, and load_mode hands the
// memory exclusively to the loader after in-flight reads have drained.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_mode,
  // Fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  // Loader port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_valid,
  output logic [DATA_W-1:0] l_rdata,
  // Memory port
  output logic              m_ce,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_d,
  input  logic [DATA_W-1:0] m_q
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StRun, StDrain, StLoad} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            f_pend_q, f_pend_d;
  logic            l_pend_q, l_pend_d;

  // Arbitration and mode sequencing.
  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (load_mode) begin
          // Stop granting immediately so DRAIN only waits for one return.
          state_d = StDrain;
        end else begin
          l_gnt = l_req && (!f_req || (starve_q == StarveMax));
          f_gnt = f_req && !l_gnt;
        end
      end
      StDrain: begin
        if (!load_mode) begin
          state_d = StRun;
        end else if (!(f_pend_q || l_pend_q)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        l_gnt = l_req;
        if (!load_mode) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (reset) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  // Starvation counter and read-return tracking.
  always_comb begin
    starve_d = starve_q;
    if (l_gnt || !l_req) begin
      starve_d = '0;
    end else if (f_gnt && (starve_q != StarveMax)) begin
      starve_d = starve_q + CntW'(1);
    end
    f_pend_d = f_gnt;
    l_pend_d = l_gnt && !l_we;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      starve_q <= '0;
      f_pend_q <= 1'b0;
      l_pend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      f_pend_q <= f_pend_d;
      l_pend_q <= l_pend_d;
    end
  end

  // Memory-side muxing and data return.
  always_comb begin
    f_valid = f_pend_q && !reset;
    l_valid = l_pend_q && !reset;
    m_ce    = f_gnt || l_gnt || f_valid || l_valid;
    m_we    = l_gnt && l_we;
    m_addr  = l_gnt ? l_addr : f_addr;
    m_d     = l_wdata;
    f_rdata = m_q;
    l_rdata = m_q;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules and memory.
module tb_imem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          reset, load_mode;
  logic          f_req, f_gnt, f_valid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          l_req, l_we, l_gnt, l_valid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          m_ce, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_d, m_q;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] ref_mem [1024];

  // Synchronous RAM environment; unwritten words return their preload pattern.
  logic [DW-1:0] mem [1024];
  bit            written [1024];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 32'h5A00_0000 ^ ({22'd0, a} * 32'h0001_0F0F);
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_ce) begin
      if (m_we) begin
        mem[m_addr]     <= m_d;
        written[m_addr] <= 1'b1;
      end else begin
        m_q <= written[m_addr] ? mem[m_addr] : init_word(m_addr);
      end
    end
  end

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .load_mode(load_mode),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_valid(l_valid), .l_rdata(l_rdata),
    .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_d(m_d), .m_q(m_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_mode = 1'b0; idle_inputs();
    tick(); tick();
    // Requests while reset is high must not be granted.
    f_req = 1'b1; l_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({f_gnt, l_gnt} !== 2'b00) begin
      n_err++; $display("FAIL reset_gnt_suppress got=%b want=00", {f_gnt, l_gnt});
    end
    tick();
    reset = 1'b0; idle_inputs();
    @(negedge clk);
    n_vec++;
    if ({f_gnt, l_gnt, f_valid, l_valid, m_ce, m_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=000000",
               {f_gnt, l_gnt, f_valid, l_valid, m_ce, m_we});
    end
    tick();
  endtask

  task automatic test_fetch_burst();
    for (int i = 0; i < 5; i++) begin
      f_req  = (i < 3);
      f_addr = AW'(i);
      @(negedge clk);
      n_vec++;
      if (f_gnt !== (i < 3) || l_gnt !== 1'b0) begin
        n_err++; $display("FAIL burst_gnt[%0d] got f=%b l=%b want f=%b l=0", i, f_gnt, l_gnt, i < 3);
      end
      n_vec++;
      if (f_valid !== (i >= 1 && i <= 3)) begin
        n_err++; $display("FAIL burst_valid[%0d] got=%b want=%b", i, f_valid, i >= 1 && i <= 3);
      end
      if (i >= 1 && i <= 3) begin
        n_vec++;
        if (f_rdata !== ref_mem[i-1]) begin
          n_err++; $display("FAIL burst_data[%0d] got=%h want=%h", i, f_rdata, ref_mem[i-1]);
        end
      end
      n_vec++;
      if (m_ce !== (i <= 3)) begin
        n_err++; $display("FAIL burst_mce[%0d] got=%b want=%b", i, m_ce, i <= 3);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    int unsigned fa = 0;
    bit pf = 0, pl = 0;
    logic [DW-1:0] pf_data = '0;
    for (int k = 0; k < 11; k++) begin
      bit exp_l, exp_f;
      f_req = (k < 10); f_addr = AW'(fa);
      l_req = (k < 10); l_we = 1'b0; l_addr = 10'h3FF;
      exp_l = (k == 4) || (k == 9);
      exp_f = (k < 10) && !exp_l;
      @(negedge clk);
      n_vec++;
      if ({f_gnt, l_gnt} !== {exp_f, exp_l}) begin
        n_err++; $display("FAIL starve_gnt[%0d] got=%b want=%b", k, {f_gnt, l_gnt}, {exp_f, exp_l});
      end
      if (exp_l) begin
        n_vec++;
        if (m_addr !== 10'h3FF || m_we !== 1'b0) begin
          n_err++; $display("FAIL starve_maddr[%0d] got=%h/%b want=3ff/0", k, m_addr, m_we);
        end
      end
      n_vec++;
      if ({f_valid, l_valid} !== {pf, pl}) begin
        n_err++; $display("FAIL starve_valid[%0d] got=%b want=%b", k, {f_valid, l_valid}, {pf, pl});
      end
      if (pl) begin
        n_vec++;
        if (l_rdata !== ref_mem[10'h3FF]) begin
          n_err++; $display("FAIL starve_ldata[%0d] got=%h want=%h", k, l_rdata, ref_mem[10'h3FF]);
        end
      end
      if (pf) begin
        n_vec++;
        if (f_rdata !== pf_data) begin
          n_err++; $display("FAIL starve_fdata[%0d] got=%h want=%h", k, f_rdata, pf_data);
        end
      end
      pf = exp_f; pl = exp_l; pf_data = ref_mem[fa];
      if (exp_f) fa++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_load_mode();
    // Cycle A: fetch read of 5 in RUN.
    f_req = 1'b1; f_addr = 10'h005;
    @(negedge clk);
    n_vec++;
    if (f_gnt !== 1'b1) begin n_err++; $display("FAIL load_a_fgnt got=%b want=1", f_gnt); end
    tick();
    // Cycle B: load_mode rises; the earlier fetch must still return.
    load_mode = 1'b1; f_addr = 10'h010;
    @(negedge clk);
    n_vec++;
    if (f_gnt !== 1'b0 || f_valid !== 1'b1 || f_rdata !== ref_mem[5]) begin
      n_err++;
      $display("FAIL load_b_return got gnt=%b v=%b d=%h want 0/1/%h", f_gnt, f_valid, f_rdata,
               ref_mem[5]);
    end
    tick();
    // Cycle C: DRAIN, no grants.
    l_req = 1'b1; l_we = 1'b1; l_addr = 10'h010; l_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++;
    if ({f_gnt, l_gnt, f_valid} !== 3'b000) begin
      n_err++; $display("FAIL load_c_drain got=%b want=000", {f_gnt, l_gnt, f_valid});
    end
    tick();
    // Cycle D: LOAD, loader write granted.
    @(negedge clk);
    n_vec++;
    if ({f_gnt, l_gnt, m_we, m_ce} !== 4'b0111 || m_addr !== 10'h010 || m_d !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL load_d_write got gwec=%b a=%h d=%h want 0111/010/deadbeef",
               {f_gnt, l_gnt, m_we, m_ce}, m_addr, m_d);
    end
    ref_mem[10'h010] = 32'hDEADBEEF;
    tick();
    // Cycle E: loader read back; the write must not produce l_valid.
    l_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({f_gnt, l_gnt, m_we, l_valid} !== 4'b0100) begin
      n_err++; $display("FAIL load_e_read got=%b want=0100", {f_gnt, l_gnt, m_we, l_valid});
    end
    tick();
    // Cycle F: load_mode drops; still LOAD this cycle, loader read returns.
    load_mode = 1'b0; l_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (f_gnt !== 1'b0 || l_valid !== 1'b1 || l_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL load_f_lret got gnt=%b v=%b d=%h want 0/1/deadbeef", f_gnt, l_valid, l_rdata);
    end
    tick();
    // Cycle G: RUN, fetch of 0x010 granted.
    @(negedge clk);
    n_vec++;
    if (f_gnt !== 1'b1 || m_addr !== 10'h010) begin
      n_err++; $display("FAIL readback_gnt got=%b/%h want=1/010", f_gnt, m_addr);
    end
    tick();
    f_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (f_valid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL readback_data got=%b/%h want=1/deadbeef", f_valid, f_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_drain_abort();
    load_mode = 1'b1;
    tick();
    // In DRAIN; load_mode drops so the next cycle is RUN again.
    load_mode = 1'b0; f_req = 1'b1; f_addr = 10'h009;
    @(negedge clk);
    n_vec++;
    if (f_gnt !== 1'b0) begin n_err++; $display("FAIL drain_nogrant got=%b want=0", f_gnt); end
    tick();
    @(negedge clk);
    n_vec++;
    if (f_gnt !== 1'b1) begin n_err++; $display("FAIL drain_abort_run got=%b want=1", f_gnt); end
    tick();
    f_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (f_valid !== 1'b1 || f_rdata !== ref_mem[9]) begin
      n_err++; $display("FAIL drain_abort_data got=%b/%h want=1/%h", f_valid, f_rdata, ref_mem[9]);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    f_req = 1'b1; f_addr = 10'h007;
    @(negedge clk);
    n_vec++;
    if (f_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_gnt got=%b want=1", f_gnt); end
    tick();
    reset = 1'b1; f_req = 1'b0; l_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({f_gnt, l_gnt} !== 2'b00) begin
      n_err++; $display("FAIL midrst_suppress got=%b want=00", {f_gnt, l_gnt});
    end
    tick();
    reset = 1'b0; l_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({f_gnt, l_gnt, f_valid, l_valid, m_ce, m_we} !== 6'b0) begin
      n_err++;
      $display("FAIL midrst_outputs got=%b want=000000",
               {f_gnt, l_gnt, f_valid, l_valid, m_ce, m_we});
    end
    tick();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({m_ce, f_gnt, l_gnt, f_valid, l_valid} !== 5'b0) begin
        n_err++;
        $display("FAIL idle[%0d] got=%b want=00000", i, {m_ce, f_gnt, l_gnt, f_valid, l_valid});
      end
      tick();
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom);
  endfunction

  // Randomized traffic: each requester holds its request until granted.
  task automatic test_random();
    int unsigned streak = 0;
    bit pf = 0, pl = 0;
    logic [DW-1:0] pf_data = '0, pl_data = '0;
    for (int c = 0; c < 400; c++) begin
      bit exp_f, exp_l;
      exp_l = l_req && (!f_req || streak == SMAX);
      exp_f = f_req && !exp_l;
      @(negedge clk);
      n_vec++;
      if ({f_gnt, l_gnt} !== {exp_f, exp_l}) begin
        n_err++; $display("FAIL rnd_gnt[%0d] got=%b want=%b", c, {f_gnt, l_gnt}, {exp_f, exp_l});
      end
      n_vec++;
      if ({f_valid, l_valid} !== {pf, pl} || (pf && f_rdata !== pf_data) ||
          (pl && l_rdata !== pl_data)) begin
        n_err++;
        $display("FAIL rnd_return[%0d] got v=%b f=%h l=%h want v=%b f=%h l=%h", c,
                 {f_valid, l_valid}, f_rdata, l_rdata, {pf, pl}, pf_data, pl_data);
      end
      n_vec++;
      if (m_ce !== (exp_f || exp_l || pf || pl) || m_we !== (exp_l && l_we) ||
          (exp_l && m_addr !== l_addr) || (exp_f && m_addr !== f_addr) ||
          (exp_l && l_we && m_d !== l_wdata)) begin
        n_err++;
        $display("FAIL rnd_mem[%0d] got ce=%b we=%b a=%h d=%h", c, m_ce, m_we, m_addr, m_d);
      end
      pf = exp_f; pf_data = ref_mem[f_addr];
      pl = exp_l && !l_we; pl_data = ref_mem[l_addr];
      if (exp_l && l_we) ref_mem[l_addr] = l_wdata;
      if (exp_l || !l_req) streak = 0;
      else if (exp_f && streak < SMAX) streak++;
      tick();
      if (!f_req || exp_f) begin
        f_req = ($urandom_range(0, 3) != 0); f_addr = rand_addr();
      end
      if (!l_req || exp_l) begin
        l_req = $urandom_range(0, 1); l_we = $urandom_range(0, 1);
        l_addr = rand_addr(); l_wdata = $urandom;
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(AW'(i));
    test_reset();
    test_fetch_burst();
    test_starvation();
    test_load_mode();
    test_drain_abort();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
